// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronises sri, centre-samples start/data/parity/stop on the
// oversampling enable, and emits one-clk byte strobes with parity/framing/break flags.
`timescale 1ns/1ps
module uart_rx_frame #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned OS_RATE     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       brclk,
  input  logic       sri,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       stick,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       break_det,
  output logic       busy
);

  localparam int unsigned CW = $clog2(OS_RATE);
  localparam logic [CW-1:0] MidTick = CW'(OS_RATE / 2 - 1);
  localparam logic [CW-1:0] EndTick = CW'(OS_RATE - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHi} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], sri};
  end

  assign rx = sync_q[SYNC_STAGES-1];

  state_e      state_q;
  logic [CW-1:0] tick_q;
  logic [2:0]  bit_q;
  logic [1:0]  wls_q;
  logic        pen_q, eps_q, stick_q;
  logic [7:0]  shift_q;
  logic        zero_q;
  logic        perr_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q, parity_err_q, frame_err_q, break_q;

  logic       tick_end;
  logic [2:0] last_bit;
  logic       exp_par;

  assign tick_end = (tick_q == EndTick);
  assign last_bit = {1'b0, wls_q} + 3'd4;
  // Unused MSBs of shift_q stay 0, so reducing over all 8 bits is safe
  assign exp_par  = stick_q ? ~eps_q : (eps_q ? ^shift_q : ~^shift_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tick_q       <= '0;
      bit_q        <= '0;
      wls_q        <= '0;
      pen_q        <= 1'b0;
      eps_q        <= 1'b0;
      stick_q      <= 1'b0;
      shift_q      <= '0;
      zero_q       <= 1'b0;
      perr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_q      <= 1'b0;
    end else begin
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_q      <= 1'b0;
      if (brclk) begin
        unique case (state_q)
          StIdle: begin
            if (!rx) begin
              state_q <= StStart;
              tick_q  <= '0;
              wls_q   <= wls;
              pen_q   <= pen;
              eps_q   <= eps;
              stick_q <= stick;
            end
          end
          StStart: begin
            if (tick_q == MidTick) begin
              tick_q <= '0;
              if (!rx) begin
                state_q <= StData;
                bit_q   <= '0;
                shift_q <= '0;
                zero_q  <= 1'b1;
                perr_q  <= 1'b0;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          StData: begin
            if (tick_end) begin
              tick_q         <= '0;
              shift_q[bit_q] <= rx;
              if (rx) zero_q <= 1'b0;
              if (bit_q == last_bit) state_q <= pen_q ? StParity : StStop;
              else                   bit_q   <= bit_q + 3'd1;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          StParity: begin
            if (tick_end) begin
              tick_q  <= '0;
              if (rx) zero_q <= 1'b0;
              perr_q  <= (rx != exp_par);
              state_q <= StStop;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          StStop: begin
            if (tick_end) begin
              tick_q       <= '0;
              rx_valid_q   <= 1'b1;
              rx_data_q    <= shift_q;
              parity_err_q <= perr_q;
              frame_err_q  <= ~rx;
              break_q      <= ~rx & zero_q;
              state_q      <= rx ? StIdle : StWaitHi;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          StWaitHi: begin
            // Hold off new start detection until the break/low line releases
            if (rx) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_q;
  assign busy       = (state_q != StIdle);

endmodule
